// File: rtl/insight_tl_a_capture.sv
// Passive TileLink A-channel trace tap: filters whole messages by opcode and
// address window, tags every captured beat with its index inside the message
// and buffers the beats in a DEPTH-entry FIFO that the trace encoder drains.
module insight_tl_a_capture #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int SRC_W  = 3,
    parameter int SIZE_W = 4,
    parameter int DEPTH  = 8,
    parameter int BEAT_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tap_valid,
    input  logic                       tap_ready,
    input  logic [2:0]                 tap_opcode,
    input  logic [2:0]                 tap_param,
    input  logic [SIZE_W-1:0]          tap_size,
    input  logic [SRC_W-1:0]           tap_source,
    input  logic [ADDR_W-1:0]          tap_address,
    input  logic [DATA_W/8-1:0]        tap_mask,
    input  logic [DATA_W-1:0]          tap_data,
    input  logic                       tap_corrupt,
    input  logic                       cfg_enable,
    input  logic [7:0]                 cfg_opcode_en,
    input  logic [ADDR_W-1:0]          cfg_addr_base,
    input  logic [ADDR_W-1:0]          cfg_addr_mask,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [2:0]                 rec_opcode,
    output logic [2:0]                 rec_param,
    output logic [SIZE_W-1:0]          rec_size,
    output logic [SRC_W-1:0]           rec_source,
    output logic [ADDR_W-1:0]          rec_address,
    output logic [BEAT_W-1:0]          rec_beat,
    output logic                       rec_last,
    output logic [DATA_W/8-1:0]        rec_mask,
    output logic [DATA_W-1:0]          rec_data,
    output logic                       rec_corrupt,
    output logic [15:0]                drop_count,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int LG     = $clog2(MASK_W);
    localparam int REC_W  = 3 + 3 + SIZE_W + SRC_W + ADDR_W + BEAT_W + 1 + MASK_W + DATA_W + 1;
    localparam logic [AW:0]  DEPTH_V = (AW + 1)'(DEPTH);
    localparam logic [31:0]  LG_V    = 32'(LG);

    typedef enum logic {IDLE, BURST} state_t;

    // Index of the final beat (N-1); only data-carrying opcodes 0..3 wider than a beat span several beats.
    function automatic logic [BEAT_W-1:0] last_index(input logic [2:0] op, input logic [SIZE_W-1:0] sz);
        logic [31:0] n;
        n = 32'd0;
        if (!op[2] && (32'(sz) > LG_V))
            n = (32'd1 << (32'(sz) - LG_V)) - 32'd1;
        return n[BEAT_W-1:0];
    endfunction

    // Saturating increment for the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              state, state_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic                keep_q, keep_nxt;
    logic                hdr_load;

    logic [2:0]          hdr_opcode, hdr_param;
    logic [SIZE_W-1:0]   hdr_size;
    logic [SRC_W-1:0]    hdr_source;
    logic [ADDR_W-1:0]   hdr_address;
    logic [BEAT_W-1:0]   hdr_last_idx;

    logic                fire;
    logic [BEAT_W-1:0]   live_last_idx;
    logic                live_keep;

    logic                vld_p0;
    logic [2:0]          opcode_p0, param_p0;
    logic [SIZE_W-1:0]   size_p0;
    logic [SRC_W-1:0]    source_p0;
    logic [ADDR_W-1:0]   address_p0;
    logic [BEAT_W-1:0]   beat_p0;
    logic                last_p0;
    logic [REC_W-1:0]    rec_p0;

    logic [REC_W-1:0]    mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         occ;
    logic                pop, push_ok, drop;
    logic [REC_W-1:0]    head;

    assign fire          = tap_valid & tap_ready;
    assign live_last_idx = last_index(tap_opcode, tap_size);
    assign live_keep     = cfg_enable & cfg_opcode_en[tap_opcode]
                         & ((tap_address & cfg_addr_mask) == (cfg_addr_base & cfg_addr_mask));

    // Message tracker: first beats use live header and decide keep; burst beats reuse the latched header.
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        keep_nxt     = keep_q;
        hdr_load     = 1'b0;
        vld_p0       = 1'b0;
        opcode_p0    = tap_opcode;
        param_p0     = tap_param;
        size_p0      = tap_size;
        source_p0    = tap_source;
        address_p0   = tap_address;
        beat_p0      = '0;
        last_p0      = (live_last_idx == '0);
        case (state)
            IDLE: begin
                if (fire) begin
                    hdr_load = 1'b1;
                    keep_nxt = live_keep;
                    vld_p0   = live_keep;
                    if (live_last_idx != '0) begin
                        state_nxt    = BURST;
                        beat_cnt_nxt = BEAT_W'(1);
                    end
                end
            end
            BURST: begin
                opcode_p0  = hdr_opcode;
                param_p0   = hdr_param;
                size_p0    = hdr_size;
                source_p0  = hdr_source;
                address_p0 = hdr_address;
                beat_p0    = beat_cnt;
                last_p0    = (beat_cnt == hdr_last_idx);
                if (fire) begin
                    vld_p0 = keep_q;
                    if (last_p0) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + BEAT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rec_p0 = {opcode_p0, param_p0, size_p0, source_p0, address_p0,
                     beat_p0, last_p0, tap_mask, tap_data, tap_corrupt};

    // Tracker control state; reset aborts any burst in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            keep_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            keep_q   <= keep_nxt;
        end
    end

    // Header latch of the first beat; only consulted while in BURST, so no reset needed.
    always_ff @(posedge clock) begin
        if (hdr_load) begin
            hdr_opcode   <= tap_opcode;
            hdr_param    <= tap_param;
            hdr_size     <= tap_size;
            hdr_source   <= tap_source;
            hdr_address  <= tap_address;
            hdr_last_idx <= live_last_idx;
        end
    end

    // ---- stage p0 -> FIFO: a full FIFO still accepts a beat when the head pops that cycle
    assign pop     = rec_valid & rec_ready;
    assign push_ok = vld_p0 & ((occ != DEPTH_V) | pop);
    assign drop    = vld_p0 & ~push_ok;

    // FIFO storage; when full, write and read share a slot, and the read sees the old entry.
    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr] <= rec_p0;
    end

    // FIFO pointers, occupancy and drop accounting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   occ <= occ + (AW + 1)'(1);
                2'b01:   occ <= occ - (AW + 1)'(1);
                default: occ <= occ;
            endcase
            if (drop) drop_count <= sat_inc16(drop_count);
        end
    end

    assign rec_valid = (occ != '0);
    assign occupancy = occ;
    // Head is forced to zero when empty so stale storage never shows on the outputs.
    assign head      = rec_valid ? mem[rd_ptr] : '0;
    assign {rec_opcode, rec_param, rec_size, rec_source, rec_address,
            rec_beat, rec_last, rec_mask, rec_data, rec_corrupt} = head;

endmodule
